// File: rtl/spi_minion_adapter_if.sv
// Packet/stream bundle between the SPI minion adapter, the minion shifter and the device stage.
interface spi_minion_adapter_if #(parameter int nbits = 34);
  logic             pull_en;
  logic [nbits-1:0] pull_msg;
  logic             push_en;
  logic [nbits-1:0] push_msg;
  logic [nbits-3:0] recv_msg;
  logic             recv_val;
  logic             recv_rdy;
  logic [nbits-3:0] send_msg;
  logic             send_val;
  logic             send_rdy;
  logic             overflow;

  modport slave (
    input  pull_en, push_en, push_msg, recv_rdy, send_msg, send_val,
    output pull_msg, recv_msg, recv_val, send_rdy, overflow
  );

  modport master (
    output pull_en, push_en, push_msg, recv_rdy, send_msg, send_val,
    input  pull_msg, recv_msg, recv_val, send_rdy, overflow
  );
endinterface

// File: rtl/spi_minion_adapter.sv
// Generic counted FIFO: 1-cycle enqueue-to-head latency, combinational head (0 when empty).
// Backpressure: enq_rdy drops when full on registered count; a same-cycle dequeue does not free room.
module spi_minion_adapter_fifo #(
  parameter int width = 32,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_vld,
  output logic             enq_rdy,
  input  logic [width-1:0] enq_dat,
  output logic             deq_vld,
  input  logic             deq_rdy,
  output logic [width-1:0] deq_dat
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [cw-1:0]    count;
  logic             do_enq;
  logic             do_deq;

  assign enq_rdy = (count != cw'(depth));
  assign deq_vld = (count != '0);
  assign deq_dat = deq_vld ? mem[rd_ptr] : '0;
  assign do_enq  = enq_vld & enq_rdy;
  assign do_deq  = deq_rdy & deq_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an empty count masks stale entries.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_dat;
  end
endmodule

// SPI minion packet <-> RX/TX valid/ready stream adapter with val/spc flow-control bits.
// Latency: pull_msg valid the cycle after pull_en; pushed payload visible on recv the cycle after push_en.
// Backpressure: full RX drops write packets (sticky overflow); full TX deasserts send_rdy.
module spi_minion_adapter #(
  parameter int nbits       = 34,
  parameter int num_entries = 2
) (
  input logic                 clk,
  input logic                 reset,
  spi_minion_adapter_if.slave bus
);
  localparam int pw = nbits - 2;

  logic [pw-1:0]    tx_head;
  logic             tx_vld;
  logic             rx_rdy;
  logic             rx_enq;
  logic             tx_deq;
  logic             pulled_val;
  logic             overflow_q;
  logic [nbits-1:0] pull_msg_q;

  assign rx_enq = bus.push_en & bus.push_msg[nbits-1];
  // Only dequeue an entry the master was actually shown on the last pull.
  assign tx_deq = bus.push_en & bus.push_msg[nbits-2] & pulled_val;

  spi_minion_adapter_fifo #(.width(pw), .depth(num_entries)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .enq_vld (rx_enq),
    .enq_rdy (rx_rdy),
    .enq_dat (bus.push_msg[pw-1:0]),
    .deq_vld (bus.recv_val),
    .deq_rdy (bus.recv_rdy),
    .deq_dat (bus.recv_msg)
  );

  spi_minion_adapter_fifo #(.width(pw), .depth(num_entries)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .enq_vld (bus.send_val),
    .enq_rdy (bus.send_rdy),
    .enq_dat (bus.send_msg),
    .deq_vld (tx_vld),
    .deq_rdy (tx_deq),
    .deq_dat (tx_head)
  );

  // A same-edge pull samples pre-edge FIFO state and wins over the pulled_val clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pull_msg_q <= '0;
      pulled_val <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (rx_enq && !rx_rdy) overflow_q <= 1'b1;
      if (bus.pull_en) begin
        pull_msg_q <= {tx_vld, rx_rdy, tx_head};
        pulled_val <= tx_vld;
      end else if (tx_deq) begin
        pulled_val <= 1'b0;
      end
    end
  end

  assign bus.pull_msg = pull_msg_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_spi_minion_adapter.sv
// Scoreboard bench for spi_minion_adapter (nbits=34, num_entries=2).
module tb_spi_minion_adapter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   rx_cnt = 0;
  logic [31:0] exp_rx[$];
  logic [33:0] exp_pull[$];
  logic [33:0] p;
  logic [31:0] r;

  spi_minion_adapter_if #(.nbits(34)) bus ();

  spi_minion_adapter #(.nbits(34), .num_entries(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] d);
    if (rx_cnt < 2) begin
      exp_rx.push_back(d);
      rx_cnt++;
    end
    bus.push_en = 1'b1;
    bus.push_msg = {1'b1, 1'b0, d};
    step();
    bus.push_en = 1'b0;
    bus.push_msg = '0;
  endtask

  task automatic do_rd();
    bus.push_en = 1'b1;
    bus.push_msg = {1'b0, 1'b1, 32'h0};
    step();
    bus.push_en = 1'b0;
    bus.push_msg = '0;
  endtask

  task automatic do_pull(input logic [33:0] e);
    exp_pull.push_back(e);
    bus.pull_en = 1'b1;
    step();
    bus.pull_en = 1'b0;
  endtask

  task automatic do_send(input logic [31:0] d);
    bus.send_val = 1'b1;
    bus.send_msg = d;
    step();
    bus.send_val = 1'b0;
    bus.send_msg = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    exp_rx.delete();
    exp_pull.delete();
    rx_cnt = 0;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (bus.recv_val !== 1'b0) begin bad++; $display("FAIL reset_recv_val got %b want 0", bus.recv_val); end
    total++; if (bus.send_rdy !== 1'b1) begin bad++; $display("FAIL reset_send_rdy got %b want 1", bus.send_rdy); end
    total++; if (bus.pull_msg !== 34'h0) begin bad++; $display("FAIL reset_pull_msg got %h want 0", bus.pull_msg); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    reset = 1'b1;
    step();
    do_write(32'h1); do_write(32'h2); do_write(32'h3);
    do_send(32'h77);
    do_pull({1'b1, 1'b0, 32'h77});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL pre_reset_pull got %h want %h", bus.pull_msg, p); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL pre_reset_overflow got %b want 1", bus.overflow); end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    total++; if (bus.recv_val !== 1'b0) begin bad++; $display("FAIL async_reset_recv_val got %b want 0", bus.recv_val); end
    step(); step();
    reset = 1'b1;
    step();
    exp_rx.delete();
    rx_cnt = 0;
    total++; if (bus.recv_val !== 1'b0) begin bad++; $display("FAIL mid_reset_recv_val got %b want 0", bus.recv_val); end
    total++; if (bus.send_rdy !== 1'b1) begin bad++; $display("FAIL mid_reset_send_rdy got %b want 1", bus.send_rdy); end
    total++; if (bus.pull_msg !== 34'h0) begin bad++; $display("FAIL mid_reset_pull_msg got %h want 0", bus.pull_msg); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL mid_reset_overflow got %b want 0", bus.overflow); end
    do_pull({1'b0, 1'b1, 32'h0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL post_reset_pull got %h want %h", bus.pull_msg, p); end
  endtask

  task automatic test_write_path();
    bus.recv_rdy = 1'b0;
    do_write(32'hDEADBEEF);
    total++; if (bus.recv_val !== 1'b1) begin bad++; $display("FAIL wr_recv_val got %b want 1", bus.recv_val); end
    total++; if (bus.recv_msg !== exp_rx[0]) begin bad++; $display("FAIL wr_recv_msg got %h want %h", bus.recv_msg, exp_rx[0]); end
    step();
    total++; if (bus.recv_msg !== exp_rx[0]) begin bad++; $display("FAIL wr_recv_hold got %h want %h", bus.recv_msg, exp_rx[0]); end
    bus.recv_rdy = 1'b1;
    step();
    bus.recv_rdy = 1'b0;
    r = exp_rx.pop_front();
    rx_cnt--;
    total++; if (bus.recv_val !== 1'b0) begin bad++; $display("FAIL wr_drained_val got %b want 0", bus.recv_val); end
    total++; if (bus.recv_msg !== 32'h0) begin bad++; $display("FAIL wr_empty_msg got %h want 0", bus.recv_msg); end
  endtask

  task automatic test_overflow();
    int n;
    do_write(32'h1); do_write(32'h2); do_write(32'h3);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    do_pull({1'b0, 1'b0, 32'h0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL ovf_pull_spc got %h want %h", bus.pull_msg, p); end
    bus.recv_rdy = 1'b1;
    n = 0;
    while (bus.recv_val === 1'b1 && n < 4) begin
      if (exp_rx.size() == 0) begin
        total++; bad++; $display("FAIL ovf_extra got %h want none", bus.recv_msg);
      end else begin
        r = exp_rx.pop_front();
        rx_cnt--;
        total++; if (bus.recv_msg !== r) begin bad++; $display("FAIL ovf_drain got %h want %h", bus.recv_msg, r); end
      end
      step();
      n++;
    end
    bus.recv_rdy = 1'b0;
    total++; if (exp_rx.size() != 0 || bus.recv_val !== 1'b0) begin bad++; $display("FAIL ovf_drain_count got left=%0d val=%b want 0", exp_rx.size(), bus.recv_val); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
  endtask

  task automatic test_read_path();
    do_send(32'hCAFE0001);
    do_pull({1'b1, 1'b1, 32'hCAFE0001});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL rd_pull got %h want %h", bus.pull_msg, p); end
    do_rd();
    do_pull({1'b0, 1'b1, 32'h0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL rd_pull_empty got %h want %h", bus.pull_msg, p); end
    do_send(32'hA0); do_send(32'hB0);
    total++; if (bus.send_rdy !== 1'b0) begin bad++; $display("FAIL rd_tx_full got %b want 0", bus.send_rdy); end
    do_pull({1'b1, 1'b1, 32'hA0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL rd_pull_a got %h want %h", bus.pull_msg, p); end
    do_rd();
    do_rd();
    do_pull({1'b1, 1'b1, 32'hB0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL rd_second_rd_ignored got %h want %h", bus.pull_msg, p); end
    do_rd();
    do_pull({1'b0, 1'b1, 32'h0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL rd_final_empty got %h want %h", bus.pull_msg, p); end
  endtask

  task automatic test_race();
    do_pull({1'b0, 1'b1, 32'h0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL race_pull0 got %h want %h", bus.pull_msg, p); end
    do_send(32'h55);
    do_rd();
    do_pull({1'b1, 1'b1, 32'h55});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL race_no_deq got %h want %h", bus.pull_msg, p); end
    do_rd();
  endtask

  task automatic test_same_edge();
    do_send(32'h111); do_send(32'h222);
    do_pull({1'b1, 1'b1, 32'h111});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL same_pull_x got %h want %h", bus.pull_msg, p); end
    exp_pull.push_back({1'b1, 1'b1, 32'h111});
    bus.pull_en = 1'b1;
    bus.push_en = 1'b1;
    bus.push_msg = {1'b0, 1'b1, 32'h0};
    step();
    bus.pull_en = 1'b0;
    bus.push_en = 1'b0;
    bus.push_msg = '0;
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL same_edge_pull got %h want %h", bus.pull_msg, p); end
    do_rd();
    do_pull({1'b0, 1'b1, 32'h0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL same_edge_drained got %h want %h", bus.pull_msg, p); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL sim_ovf_clear got %b want 0", bus.overflow); end
    do_write(32'h10); do_write(32'h11);
    bus.recv_rdy = 1'b1;
    r = exp_rx.pop_front();
    rx_cnt--;
    total++; if (bus.recv_msg !== r) begin bad++; $display("FAIL sim_head got %h want %h", bus.recv_msg, r); end
    bus.push_en = 1'b1;
    bus.push_msg = {1'b1, 1'b0, 32'hA};
    step();
    bus.push_en = 1'b0;
    bus.push_msg = '0;
    bus.recv_rdy = 1'b0;
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL sim_ovf got %b want 1", bus.overflow); end
    total++; if (bus.recv_msg !== exp_rx[0]) begin bad++; $display("FAIL sim_rx_next got %h want %h", bus.recv_msg, exp_rx[0]); end
    do_pull({1'b0, 1'b1, 32'h0});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL sim_rx_count1 got %h want %h", bus.pull_msg, p); end
    bus.recv_rdy = 1'b1;
    step();
    bus.recv_rdy = 1'b0;
    r = exp_rx.pop_front();
    rx_cnt--;
    total++; if (bus.recv_val !== 1'b0) begin bad++; $display("FAIL sim_rx_empty got %b want 0", bus.recv_val); end
    do_send(32'hD1);
    do_pull({1'b1, 1'b1, 32'hD1});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL sim_tx_pull got %h want %h", bus.pull_msg, p); end
    bus.send_val = 1'b1;
    bus.send_msg = 32'hD2;
    bus.push_en = 1'b1;
    bus.push_msg = {1'b0, 1'b1, 32'h0};
    step();
    bus.send_val = 1'b0;
    bus.push_en = 1'b0;
    bus.push_msg = '0;
    total++; if (bus.send_rdy !== 1'b1) begin bad++; $display("FAIL sim_tx_count got %b want 1", bus.send_rdy); end
    do_send(32'hD3);
    total++; if (bus.send_rdy !== 1'b0) begin bad++; $display("FAIL sim_tx_full got %b want 0", bus.send_rdy); end
    do_pull({1'b1, 1'b1, 32'hD2});
    p = exp_pull.pop_front();
    total++; if (bus.pull_msg !== p) begin bad++; $display("FAIL sim_tx_head got %h want %h", bus.pull_msg, p); end
  endtask

  initial begin
    bus.pull_en  = 1'b0;
    bus.push_en  = 1'b0;
    bus.push_msg = '0;
    bus.recv_rdy = 1'b0;
    bus.send_msg = '0;
    bus.send_val = 1'b0;
    test_reset();
    test_write_path();
    test_overflow();
    test_read_path();
    test_race();
    test_same_edge();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_minion_adapter.md
Name: spi_minion_adapter

Overview:
Packet-level adapter between the SPI minion shift register and the hardcode-bit/device stage. Converts per-transaction push/pull strobes from the minion into two buffered valid/ready streams. Received payloads go downstream to the device path. Device responses are returned to the master on later SPI transactions. Flow-control bits (val/spc) tell the master which transactions carried data.

Parameters:
nbits, 34, SPI packet width including 2 status bits; payload width is nbits-2 (>=3)
num_entries, 2, depth of each of the RX and TX FIFOs (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset; state clears while reset=0
pull_en  in  1  minion requests next outgoing packet (one cycle, start of SPI transaction)
pull_msg  out  nbits  outgoing packet {val, spc, payload[nbits-3:0]}
push_en  in  1  minion delivers received packet (one cycle, end of SPI transaction)
push_msg  in  nbits  incoming packet {val_wrt, val_rd, payload[nbits-3:0]}
recv_msg  out  nbits-2  RX FIFO head to device stage
recv_val  out  1  RX FIFO non-empty
recv_rdy  in  1  downstream accepts recv_msg
send_msg  in  nbits-2  response payload from device
send_val  in  1  send_msg valid
send_rdy  out  1  TX FIFO not full
overflow  out  1  sticky: a write packet was dropped because RX was full

Behaviour:
- Reset (reset=0, async): both FIFOs empty, pointers and counts 0, pull_msg=0, pulled_val=0, overflow=0. Outputs then read recv_val=0, send_rdy=1.
- Reset asserted mid-transaction discards all buffered data. No partial state survives.
- RX FIFO, depth num_entries, width nbits-2:
  - push_en=1 and val_wrt=1 and RX not full -> enqueue push_msg payload at the clock edge.
  - Same condition with RX full -> packet dropped; overflow set to 1 at that edge. overflow clears only on reset.
  - Full is evaluated on registered state: a simultaneous recv dequeue does not create room for the same-cycle push.
  - recv_val = RX not empty; recv_msg = head (combinational). Dequeue when recv_val & recv_rdy.
  - Empty RX -> recv_val=0, recv_msg=0.
- TX FIFO, depth num_entries:
  - send_rdy = TX not full; enqueue when send_val & send_rdy.
  - Simultaneous enqueue and dequeue on a non-empty FIFO keeps the count unchanged.
- pull_en=1 at an edge loads the pull_msg register with:
  - val = TX not empty
  - spc = RX not full
  - payload = TX head, or 0 if empty
  - The same edge sets pulled_val = val.
  - pull_msg holds until the next pull_en. Latency: pull_msg is valid the cycle after pull_en.
- push_en=1 with val_rd=1 and pulled_val=1 -> dequeue TX head at that edge, i.e. the master consumed the entry it was shown.
  - After the dequeue, pulled_val clears.
  - val_rd=1 with pulled_val=0 is ignored: no dequeue, no error.
- pull_en and push_en in the same cycle:
  - The push is processed against the old pulled_val and old FIFO state.
  - pull_msg and pulled_val take the pre-edge TX/RX status, and the TX head as it was before any same-edge dequeue.
- Pointers wrap modulo num_entries. Full/empty are distinguished by an occupancy counter of width clog2(num_entries)+1.
- No combinational path from push_en/pull_en to any output. recv_msg/recv_val depend only on state.

Test Plan:
- Reset: hold reset=0 mid-traffic with 1 entry in each FIFO, release -> recv_val=0, send_rdy=1, pull_msg=0, overflow=0.
- Write path: push_en with push_msg={1,0,32'hDEADBEEF}, recv_rdy=0 -> next cycle recv_val=1, recv_msg=32'hDEADBEEF. Raise recv_rdy -> recv_val=0 the following cycle.
- Overflow: num_entries=2, three write pushes 32'h1, 32'h2, 32'h3 with recv_rdy=0 -> third dropped, overflow=1. Draining yields 32'h1 then 32'h2 only. A pull_en before draining shows spc=0.
- Read path: send 32'hCAFE0001, then pull_en -> pull_msg={1,1,32'hCAFE0001}. push_en with val_rd=1 -> TX empty. A second pull_en -> pull_msg={0,1,0}.
- Race: pull_en with TX empty, then send 32'h55 before push_en{val_rd=1} -> no dequeue. Next pull_en shows {1,1,32'h55}.
- Simultaneous: push_en (write 32'hA) and recv dequeue in the same cycle with RX full -> 32'hA dropped, overflow=1, count decreases by 1. TX enqueue and dequeue in the same cycle -> TX count unchanged.
